mtree_run_feeder: RTL and testbench

Source side of the merge sorter tree's input protocol. It drives the tree's `din`/`dinen` buses and obeys its per-way `ful` back-pressure. Each of the 2^W_LOG ways emits a sorted run of RUN_LEN generated records followed by one terminator record. It replaces bench-only stimulus for on-chip throughput and regression runs, and its key pattern merges into a contiguous ascending sequence.

---
 rtl/mtree_run_feeder.sv | 109 ++++++++++
 tb/tb_mtree_run_feeder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mtree_run_feeder.sv
// rtl/mtree_run_feeder.sv - per-way sorted-run generator feeding the merge sorter tree inputs
module mtree_run_feeder #(
    parameter int W_LOG = 10,
    parameter int DATW  = 64,
    parameter int KEYW  = 32,
    parameter int RUNW  = 16
) (
    input  logic                         CLK,
    input  logic                         RST_X,
    input  logic                         START,
    input  logic [RUNW-1:0]              RUN_LEN,
    input  logic [(1<<W_LOG)-1:0]        FUL,
    output logic [DATW*(1<<W_LOG)-1:0]   DOT,
    output logic [(1<<W_LOG)-1:0]        DOTEN,
    output logic                         BUSY,
    output logic                         DONE
);

    localparam int WAYS = 1 << W_LOG;
    localparam int PAYW = DATW - KEYW;

    typedef enum logic [1:0] {G_IDLE, G_RUN, G_DONE} g_state_t;
    typedef enum logic [1:0] {W_DATA, W_TERM, W_FIN} w_state_t;

    g_state_t        g_state;
    g_state_t        g_next;
    logic [RUNW-1:0] len_r;
    logic            start_ok;
    logic [WAYS-1:0] fin_nxt;

    // START is only honoured when no run is in flight
    assign start_ok = START & (g_state != G_RUN);
    assign BUSY     = (g_state == G_RUN);
    assign DONE     = (g_state == G_DONE);

    // global state register and run-length latch
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            g_state <= G_IDLE;
            len_r   <= '0;
        end else begin
            g_state <= g_next;
            if (start_ok) begin
                len_r <= RUN_LEN;
            end
        end
    end

    // next global state; RUN ends as soon as the final terminator is consumed
    always_comb begin
        g_next = g_state;
        case (g_state)
            G_IDLE:  if (START) g_next = G_RUN;
            G_RUN:   if (&fin_nxt) g_next = G_DONE;
            G_DONE:  if (START) g_next = G_RUN;
            default: g_next = G_IDLE;
        endcase
    end

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        localparam logic [PAYW-1:0] PAYLOAD = PAYW'(gi);
        localparam logic [KEYW-1:0] KEY0    = KEYW'(WAYS - gi);
        localparam logic [KEYW-1:0] KSTEP   = KEYW'(WAYS);

        w_state_t        ws_r;
        logic [RUNW-1:0] cnt_r;
        logic [DATW-1:0] dot_r;
        logic [RUNW-1:0] cnt_inc;

        assign cnt_inc = cnt_r + RUNW'(1);
        assign DOTEN[gi] = BUSY & (ws_r != W_FIN) & ~FUL[gi];
        // way counts as finished if it already is, or its terminator leaves this edge
        assign fin_nxt[gi] = (ws_r == W_FIN) | ((ws_r == W_TERM) & DOTEN[gi]);
        assign DOT[DATW*gi +: DATW] = dot_r;

        // per-way record generator; the key lives in the low bits of the output register
        always_ff @(posedge CLK or negedge RST_X) begin
            if (!RST_X) begin
                ws_r  <= W_FIN;
                cnt_r <= '0;
                dot_r <= '0;
            end else if (start_ok) begin
                cnt_r <= '0;
                if (RUN_LEN == '0) begin
                    ws_r  <= W_TERM;
                    dot_r <= {PAYLOAD, {KEYW{1'b1}}};
                end else begin
                    ws_r  <= W_DATA;
                    dot_r <= {PAYLOAD, KEY0};
                end
            end else if (DOTEN[gi]) begin
                case (ws_r)
                    W_DATA: begin
                        cnt_r <= cnt_inc;
                        if (cnt_inc == len_r) begin
                            ws_r  <= W_TERM;
                            dot_r <= {PAYLOAD, {KEYW{1'b1}}};
                        end else begin
                            dot_r <= {PAYLOAD, dot_r[KEYW-1:0] + KSTEP};
                        end
                    end
                    W_TERM:  ws_r <= W_FIN;
                    default: ws_r <= W_FIN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mtree_run_feeder.sv
// tb/tb_mtree_run_feeder.sv - scoreboard bench for mtree_run_feeder
module tb_mtree_run_feeder;
    localparam int W_LOG = 2;
    localparam int WAYS  = 1 << W_LOG;
    localparam int DATW  = 64;
    localparam int KEYW  = 32;
    localparam int RUNW  = 16;

    logic                    CLK = 1'b0;
    logic                    RST_X = 1'b0;
    logic                    START = 1'b0;
    logic [RUNW-1:0]         RUN_LEN = '0;
    logic [WAYS-1:0]         FUL = '0;
    logic [DATW*WAYS-1:0]    DOT;
    logic [WAYS-1:0]         DOTEN;
    logic                    BUSY;
    logic                    DONE;

    mtree_run_feeder #(.W_LOG(W_LOG), .DATW(DATW), .KEYW(KEYW), .RUNW(RUNW)) dut (
        .CLK(CLK), .RST_X(RST_X), .START(START), .RUN_LEN(RUN_LEN), .FUL(FUL),
        .DOT(DOT), .DOTEN(DOTEN), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;
    int phase = 0;              // 0 idle, 1 run, 2 done
    bit rand_ful = 1'b0;
    logic [DATW-1:0] exp_q [WAYS][$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < WAYS; i++) if (exp_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // reference: way i produces keys k*WAYS-i for k=1..L, then an all-ones terminator
    task automatic model_start(input int len);
        logic [KEYW-1:0] k;
        for (int i = 0; i < WAYS; i++) begin
            exp_q[i].delete();
            for (int n = 1; n <= len; n++) begin
                k = KEYW'(n * WAYS - i);
                exp_q[i].push_back({32'(i), k});
            end
            exp_q[i].push_back({32'(i), 32'hFFFF_FFFF});
        end
        phase = 1;
    endtask

    // monitor: status, enables and the record at the head of each way's queue
    always @(negedge CLK) begin
        if (RST_X) begin
            if (phase == 1 && all_empty()) phase = 2;
            chk("busy", 64'(BUSY), 64'(phase == 1));
            chk("done", 64'(DONE), 64'(phase == 2));
            for (int i = 0; i < WAYS; i++) begin
                chk($sformatf("doten%0d", i), 64'(DOTEN[i]),
                    64'(phase == 1 && exp_q[i].size() != 0 && !FUL[i]));
                if (phase == 1 && exp_q[i].size() != 0) begin
                    chk($sformatf("dot%0d", i), DOT[DATW*i +: DATW], exp_q[i][0]);
                    if (DOTEN[i]) void'(exp_q[i].pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
        if (rand_ful) FUL = WAYS'($urandom);
    endtask

    task automatic start(input int len);
        START = 1'b1;
        RUN_LEN = RUNW'(len);
        step();
        START = 1'b0;
        if (phase != 1) model_start(len);
    endtask

    // counts cycles from the given start cycle index until DONE is seen
    task automatic wait_done(input int cyc0, output int cyc);
        cyc = cyc0;
        while (!DONE && cyc < 400) begin
            step();
            cyc++;
        end
        if (cyc >= 400) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got no DONE expected DONE within 400 cycles");
        end
    endtask

    int c;
    int len;

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_dot", 64'(|DOT), 64'd0);
        chk("rst_doten", 64'(DOTEN), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_done", 64'(DONE), 64'd0);
        RST_X = 1'b1;
        step();

        // free run, length 3
        start(3);
        wait_done(1, c);
        chk("free_done_cycle", 64'(c), 64'd5);

        // back-pressure on way 1 during cycles t+2..t+4
        start(3);
        step();
        FUL = 4'b0010;
        step();
        #1;
        chk("stall_doten1", 64'(DOTEN[1]), 64'd0);
        chk("stall_key1", DOT[DATW +: DATW], {32'd1, 32'd7});
        step();
        step();
        FUL = '0;
        wait_done(5, c);
        chk("bp_done_cycle", 64'(c), 64'd8);

        // zero-length run
        start(0);
        wait_done(1, c);
        chk("zero_done_cycle", 64'(c), 64'd2);

        // START with another length during RUN is ignored
        start(3);
        start(5);
        wait_done(2, c);
        chk("ignore_done_cycle", 64'(c), 64'd5);

        // asynchronous reset mid-run, then a clean restart
        start(3);
        step();
        #1;
        RST_X = 1'b0;
        #1;
        chk("arst_dot", 64'(|DOT), 64'd0);
        chk("arst_doten", 64'(DOTEN), 64'd0);
        chk("arst_busy", 64'(BUSY), 64'd0);
        chk("arst_done", 64'(DONE), 64'd0);
        for (int i = 0; i < WAYS; i++) exp_q[i].delete();
        phase = 0;
        #1;
        RST_X = 1'b1;
        step();
        start(3);
        wait_done(1, c);
        chk("restart_done_cycle", 64'(c), 64'd5);

        // randomized lengths and back-pressure
        rand_ful = 1'b1;
        repeat (25) begin
            len = $urandom_range(0, 5);
            start(len);
            if ($urandom_range(0, 3) == 0) start($urandom_range(0, 7));
            wait_done(1, c);
        end
        rand_ful = 1'b0;
        FUL = '0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
